// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: FSM encoding, BCD limits and HH:MM digit-field positions shared by the time keeper and the alarm display driver
package alarm_clock_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ENTRY = 2'd1, ST_COMMIT = 2'd2} state_t;
  localparam logic [15:0] BCD_MAX  = 16'h2359;
  localparam logic [15:0] BCD_ZERO = 16'h0000;
  localparam int MS_HOUR = 12;
  localparam int LS_HOUR = 8;
  localparam int MS_MIN  = 4;
  localparam int LS_MIN  = 0;
  function automatic logic hhmm_ok(input logic [15:0] t);
    return t <= BCD_MAX && t[MS_MIN+:4] <= 4'd5 && t[LS_MIN+:4] <= 4'd9 && t[LS_HOUR+:4] <= 4'd9 &&
           !(t[MS_HOUR+:4] == 4'd2 && t[LS_HOUR+:4] > 4'd3);
  endfunction
endpackage

// File: rtl/time_keeper_bcd_minute_inc.sv
// bcd_minute_inc: combinational next-minute of a BCD HH:MM value, 23:59 wraps to 00:00
//   i_time  BCD {ms_hour, ls_hour, ms_min, ls_min}
//   o_time  i_time plus one minute, same packing
module bcd_minute_inc
  import alarm_clock_pkg::*;
(
  input  logic [15:0] i_time,
  output logic [15:0] o_time
);
  logic [3:0] w_mh, w_lh, w_mm, w_lm;
  assign w_mh = i_time[MS_HOUR+:4];
  assign w_lh = i_time[LS_HOUR+:4];
  assign w_mm = i_time[MS_MIN+:4];
  assign w_lm = i_time[LS_MIN+:4];
  always_comb
    o_time = (i_time == BCD_MAX) ? BCD_ZERO :
             (w_lm != 4'd9) ? {w_mh, w_lh, w_mm, w_lm + 4'd1} :
             (w_mm != 4'd5) ? {w_mh, w_lh, w_mm + 4'd1, 4'd0} :
             (w_lh != 4'd9) ? {w_mh, w_lh + 4'd1, 8'h00} :
                              {w_mh + 4'd1, 12'h000};
endmodule

// File: rtl/time_keeper.sv
// time_keeper: BCD HH:MM clock with keypad entry of current and alarm time
//   in : clk, reset (sync, active high), one_second tick, key_valid/key_value digit strobe,
//        load_time / load_alarm commit pulses, key_clear
//   out: current_time, alarm_time, key_buffer (BCD HH:MM), entry_active, one_minute, load_error
//   TIME_KEEPER_ENTRY_TIMEOUT_EN: abandon an idle partial entry after ENTRY_TIMEOUT seconds
module time_keeper
  import alarm_clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_MIN = 60,
  parameter int unsigned ENTRY_TIMEOUT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_second,
  input  logic        key_valid,
  input  logic [3:0]  key_value,
  input  logic        load_time,
  input  logic        load_alarm,
  input  logic        key_clear,
  output logic [15:0] current_time,
  output logic [15:0] alarm_time,
  output logic [15:0] key_buffer,
  output logic        entry_active,
  output logic        one_minute,
  output logic        load_error
);
  localparam int SW = $clog2(TICKS_PER_MIN + 1);
  state_t        r_state;
  logic [SW-1:0] r_sec;
  logic [15:0]   r_cur, r_alm, r_buf;
  logic [2:0]    r_cnt;
  logic          r_sel, r_one_minute, r_load_error;
  logic [15:0]   w_next;
  logic          w_wrap, w_commit_time, w_commit_alarm, w_key_ok, w_load;
`ifdef TIME_KEEPER_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(ENTRY_TIMEOUT + 1);
  logic [TW-1:0] r_to;
`endif
  bcd_minute_inc u_inc (.i_time(r_cur), .o_time(w_next));
  assign w_wrap         = one_second && r_sec == SW'(TICKS_PER_MIN - 1);
  // key_clear aborts a pending commit as well
  assign w_commit_time  = r_state == ST_COMMIT && r_sel && !key_clear;
  assign w_commit_alarm = r_state == ST_COMMIT && !r_sel && !key_clear;
  assign w_key_ok       = key_value <= 4'd9;
  assign w_load         = load_time || load_alarm;
  assign current_time   = r_cur;
  assign alarm_time     = r_alm;
  assign key_buffer     = r_buf;
  assign entry_active   = r_state == ST_ENTRY;
  assign one_minute     = r_one_minute;
  assign load_error     = r_load_error;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_sec        <= '0;
      r_cur        <= BCD_ZERO;
      r_alm        <= BCD_ZERO;
      r_buf        <= BCD_ZERO;
      r_cnt        <= 3'd0;
      r_sel        <= 1'b0;
      r_one_minute <= 1'b0;
      r_load_error <= 1'b0;
`ifdef TIME_KEEPER_ENTRY_TIMEOUT_EN
      r_to         <= '0;
`endif
    end else begin
      // a time commit overrides, and swallows, a coincident minute advance
      r_one_minute <= w_wrap && !w_commit_time;
      r_sec        <= w_commit_time ? '0 : w_wrap ? '0 : one_second ? r_sec + SW'(1) : r_sec;
      r_cur        <= w_commit_time ? r_buf : w_wrap ? w_next : r_cur;
      r_alm        <= w_commit_alarm ? r_buf : r_alm;
      r_load_error <= 1'b0;
`ifdef TIME_KEEPER_ENTRY_TIMEOUT_EN
      r_to         <= '0;
`endif
      if (key_clear) begin
        r_state <= ST_IDLE;
        r_buf   <= BCD_ZERO;
        r_cnt   <= 3'd0;
      end else begin
        case (r_state)
          ST_IDLE:
            if (w_load) r_load_error <= 1'b1;
            else if (key_valid && w_key_ok) begin
              r_buf   <= {r_buf[11:0], key_value};
              r_cnt   <= 3'd1;
              r_state <= ST_ENTRY;
            end else if (key_valid) r_load_error <= 1'b1;
          ST_ENTRY:
            if (w_load) begin
              if ((load_time ^ load_alarm) && r_cnt == 3'd4 && hhmm_ok(r_buf)) begin
                r_state <= ST_COMMIT;
                r_sel   <= load_time;
              end else begin
                r_load_error <= 1'b1;
                r_state      <= ST_IDLE;
                r_buf        <= BCD_ZERO;
                r_cnt        <= 3'd0;
              end
            end else if (key_valid) begin
              if (w_key_ok) begin
                r_buf <= {r_buf[11:0], key_value};
                r_cnt <= (r_cnt == 3'd4) ? 3'd4 : r_cnt + 3'd1;
              end else r_load_error <= 1'b1;
            end
`ifdef TIME_KEEPER_ENTRY_TIMEOUT_EN
            else if (one_second && r_to == TW'(ENTRY_TIMEOUT - 1)) begin
              r_state <= ST_IDLE;
              r_buf   <= BCD_ZERO;
              r_cnt   <= 3'd0;
            end else r_to <= r_to + TW'(one_second);
`endif
          ST_COMMIT: begin
            r_state <= ST_IDLE;
            r_buf   <= BCD_ZERO;
            r_cnt   <= 3'd0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_buf   <= BCD_ZERO;
            r_cnt   <= 3'd0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter TICKS_PER_MIN, default 60: number of one_second pulses per minute advance.
REQ-002 Parameter ENTRY_TIMEOUT, default 10: one_second pulses of key inactivity before a partial entry is abandoned (used only under REQ-030).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 one_second  input  1  single-cycle tick enable.
REQ-006 key_valid  input  1  single-cycle strobe qualifying key_value.
REQ-007 key_value  input  4  entered digit, legal 0-9.
REQ-008 load_time  input  1  pulse: commit entered digits to current_time.
REQ-009 load_alarm  input  1  pulse: commit entered digits to alarm_time.
REQ-010 key_clear  input  1  pulse: discard entry.
REQ-011 current_time  output  16  BCD HH:MM {ms_hour, ls_hour, ms_min, ls_min}.
REQ-012 alarm_time  output  16  BCD HH:MM, same packing.
REQ-013 key_buffer  output  16  last four entered digits, newest in [3:0].
REQ-014 entry_active  output  1  high while the FSM is in ENTRY.
REQ-015 one_minute  output  1  single-cycle pulse on each current_time advance.
REQ-016 load_error  output  1  single-cycle pulse on a rejected key or load.

Function
REQ-017 Second counter: counts one_second pulses 0..TICKS_PER_MIN-1; on the pulse at TICKS_PER_MIN-1 it wraps to 0, current_time advances one minute in the same edge, and one_minute pulses the following cycle.
REQ-018 Minute advance: BCD increment; ls_min 9->0 carries to ms_min; ms_min 5->0 carries to hour; ls_hour 9->0 carries to ms_hour; 23:59 -> 00:00 exactly.
REQ-019 FSM states: IDLE, ENTRY, COMMIT; no other states are reachable, and an illegal encoding returns to IDLE.
REQ-020 IDLE -> ENTRY on key_valid with key_value <= 9; the digit shifts into key_buffer[3:0] and digit count becomes 1.
REQ-021 ENTRY: each legal key shifts key_buffer left by 4 bits; count saturates at 4; a fifth or later digit drops the oldest digit.
REQ-022 Key with key_value > 9: ignored, buffer and count unchanged, load_error pulses.
REQ-023 ENTRY -> COMMIT on load_time xor load_alarm when count = 4 and key_buffer <= 16'h2359 with ms_min <= 5 and the hour <= 23; otherwise load_error pulses, the FSM returns to IDLE, and the buffer clears.
REQ-024 COMMIT (one cycle): write key_buffer to the selected register; on load_time also zero the second counter; clear key_buffer and count; go to IDLE. Latency from load pulse to updated output is 2 cycles.
REQ-025 load_time and load_alarm asserted in the same cycle: load_error pulses, nothing is committed, and the FSM returns to IDLE.
REQ-026 A load in IDLE pulses load_error; no change.
REQ-027 key_clear in any state: go to IDLE and clear the buffer, with priority over key_valid and the loads in the same cycle.
REQ-028 The COMMIT write of current_time wins over a minute advance in the same cycle, and that advance is discarded.
REQ-029 Timekeeping continues in every FSM state.

Configuration
REQ-030 Macro TIME_KEEPER_ENTRY_TIMEOUT_EN defined: in ENTRY, ENTRY_TIMEOUT consecutive one_second pulses without key_valid return the FSM to IDLE and clear the buffer, without pulsing load_error; any key_valid restarts the count. Macro undefined: no timeout counter, and ENTRY persists indefinitely.

Reset
REQ-031 Reset applies to current_time, alarm_time and key_buffer (16'h0000), the second counter (0), the FSM (IDLE), the timeout counter (0) and entry_active, one_minute and load_error (0).
REQ-032 Reset mid-entry or in COMMIT discards the entry, and neither register is written.
REQ-033 Reset has priority over every other input.

Structure
REQ-034 Shared package alarm_clock_pkg holds the FSM state encoding, the BCD constants 16'h2359 and 16'h0000, and the digit-field index constants shared with the alarm display driver.
REQ-035 Sub-module bcd_minute_inc is purely combinational: 16-bit BCD HH:MM in, next minute out, including the 23:59 wrap.

Verification
REQ-036 Preset 12:59 via keys 1,2,5,9 and load_time, then 60 one_second pulses -> current_time=16'h1300, and one_minute pulses once.
REQ-037 Preset 23:59, then advance one minute -> 16'h0000.
REQ-038 Keys 2,4,0,0 and load_alarm -> load_error pulses and alarm_time is unchanged; keys 0,6,3,0 and load_alarm -> alarm_time=16'h0630 two cycles after the load.
REQ-039 Keys 1,2,3,4,5 and load_time -> current_time=16'h2345; key_value=4'hA -> load_error pulses and the buffer is unchanged.
REQ-040 load_time and load_alarm together with 4 digits -> load_error pulses and neither register changes; load_time coincident with a minute wrap -> the loaded value holds.
REQ-041 With TIME_KEEPER_ENTRY_TIMEOUT_EN defined, key 1 then 10 one_second pulses -> entry_active=0 and key_buffer=0; reset asserted mid-entry -> all outputs are 0.
